// File: rtl/led_blink_out.sv
// Stretches one-cycle event pulses into visible LED blinks of fixed length with a fixed dark gap.
// Events arriving during a blink are queued in a saturating pending counter; drops raise a sticky ovf.
module led_blink_out #(
    parameter int ON_CYCLES  = 20000000,
    parameter int OFF_CYCLES = 10000000,
    parameter int CNT_W      = 25,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic              ovf_clr,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pending_nxt;
    logic              cnt_done;
    logic              have_work;
    logic              start;
    logic              take_pending;
    logic              queue_pulse;
    logic              ovf_set;

    assign cnt_done  = (cnt == '0);
    assign have_work = pulse || (pending != '0);
    assign start     = have_work && ((state == ST_IDLE) || ((state == ST_GAP) && cnt_done));

    // A start with an empty queue consumes the pulse itself; otherwise the queue head is consumed
    // and any same-cycle pulse is queued behind it.
    assign take_pending = start && (pending != '0);
    assign queue_pulse  = pulse && !(start && (pending == '0));

    always_comb begin
        pending_nxt = pending;
        ovf_set     = 1'b0;
        case ({queue_pulse, take_pending})
            2'b10: begin
                if (pending == PEND_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    pending_nxt = pending + PEND_W'(1);
                end
            end
            2'b01:   pending_nxt = pending - PEND_W'(1);
            default: pending_nxt = pending;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            led     <= 1'b0;
            busy    <= 1'b0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ON;
                        cnt   <= ON_LOAD;
                        led   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (cnt_done) begin
                        state <= ST_GAP;
                        cnt   <= OFF_LOAD;
                        led   <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        if (start) begin
                            state <= ST_ON;
                            cnt   <= ON_LOAD;
                            led   <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_out.sv
// Directed bench for led_blink_out with ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
// Cycle k is the interval after the k-th rising edge following reset release.
module tb_led_blink_out;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       pulse = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       ovf;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    led_blink_out #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3),
        .CNT_W     (4),
        .PEND_W    (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pulse  (pulse),
        .ovf_clr(ovf_clr),
        .led    (led),
        .busy   (busy),
        .pending(pending),
        .ovf    (ovf)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        pulse   = 1'b0;
        ovf_clr = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({led, busy, pending, ovf} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_async: led=%b busy=%b pending=%0d ovf=%b, want all 0", led, busy, pending, ovf);
        end
        clk_en = 1'b1;
        do_reset();
        while (cyc < 20) begin
            tick();
            tests_run++;
            if ({led, busy, pending, ovf} !== 5'b0) begin
                tests_failed++;
                $display("FAIL reset_idle cyc %0d: led=%b busy=%b pending=%0d ovf=%b, want all 0", cyc, led, busy, pending, ovf);
            end
        end
    endtask

    task automatic test_single();
        logic exp_led, exp_busy;
        do_reset();
        while (cyc < 25) begin
            pulse = (cyc == 10);
            tick();
            exp_led  = (cyc >= 11 && cyc <= 14);
            exp_busy = (cyc >= 11 && cyc <= 17);
            tests_run++;
            if (led !== exp_led || busy !== exp_busy || pending !== 2'd0) begin
                tests_failed++;
                $display("FAIL single cyc %0d: led=%b busy=%b pending=%0d, want led=%b busy=%b pending=0", cyc, led, busy, pending, exp_led, exp_busy);
            end
        end
        pulse = 1'b0;
    endtask

    task automatic test_queue3();
        logic       exp_led, prev;
        logic [1:0] exp_pend;
        int         blinks = 0;
        do_reset();
        prev = 1'b0;
        while (cyc < 35) begin
            pulse = (cyc >= 10 && cyc <= 12);
            tick();
            exp_led = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28);
            if (cyc < 12)      exp_pend = 2'd0;
            else if (cyc < 13) exp_pend = 2'd1;
            else if (cyc < 18) exp_pend = 2'd2;
            else if (cyc < 25) exp_pend = 2'd1;
            else               exp_pend = 2'd0;
            tests_run++;
            if (led !== exp_led || pending !== exp_pend || ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL queue3 cyc %0d: led=%b pending=%0d ovf=%b, want led=%b pending=%0d ovf=0", cyc, led, pending, ovf, exp_led, exp_pend);
            end
            if (led && !prev) blinks++;
            prev = led;
        end
        pulse = 1'b0;
        tests_run++;
        if (blinks !== 3) begin
            tests_failed++;
            $display("FAIL queue3_blinks: got %0d, want 3", blinks);
        end
    endtask

    task automatic test_overflow();
        logic       exp_ovf, prev;
        logic [1:0] exp_pend;
        int         blinks = 0;
        do_reset();
        prev = 1'b0;
        while (cyc < 45) begin
            pulse   = (cyc >= 10 && cyc <= 15);
            ovf_clr = (cyc == 14);
            tick();
            if (cyc < 12)      exp_pend = 2'd0;
            else if (cyc < 13) exp_pend = 2'd1;
            else if (cyc < 14) exp_pend = 2'd2;
            else if (cyc < 18) exp_pend = 2'd3;
            else if (cyc < 25) exp_pend = 2'd2;
            else if (cyc < 32) exp_pend = 2'd1;
            else               exp_pend = 2'd0;
            exp_ovf = (cyc >= 15);
            tests_run++;
            if (pending !== exp_pend || ovf !== exp_ovf) begin
                tests_failed++;
                $display("FAIL overflow cyc %0d: pending=%0d ovf=%b, want pending=%0d ovf=%b", cyc, pending, ovf, exp_pend, exp_ovf);
            end
            if (led && !prev) blinks++;
            prev = led;
        end
        pulse = 1'b0;
        tests_run++;
        if (blinks !== 4) begin
            tests_failed++;
            $display("FAIL overflow_blinks: got %0d, want 4", blinks);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clr: ovf=%b, want 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_led, prev;
        logic [1:0] exp_pend;
        int         blinks = 0;
        do_reset();
        prev = 1'b0;
        while (cyc < 36) begin
            pulse = (cyc == 10 || cyc == 11 || cyc == 17);
            tick();
            exp_led = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28);
            exp_pend = (cyc >= 12 && cyc <= 24) ? 2'd1 : 2'd0;
            tests_run++;
            if (led !== exp_led || pending !== exp_pend || busy !== (cyc >= 11 && cyc <= 31)) begin
                tests_failed++;
                $display("FAIL back_to_back cyc %0d: led=%b pending=%0d busy=%b, want led=%b pending=%0d", cyc, led, pending, busy, exp_led, exp_pend);
            end
            if (led && !prev) blinks++;
            prev = led;
        end
        pulse = 1'b0;
        tests_run++;
        if (blinks !== 3) begin
            tests_failed++;
            $display("FAIL back_to_back_blinks: got %0d, want 3", blinks);
        end
    endtask

    task automatic test_reset_mid_blink();
        do_reset();
        while (cyc < 13) begin
            pulse = (cyc >= 10 && cyc <= 12);
            tick();
        end
        pulse = 1'b0;
        tests_run++;
        if (led !== 1'b1 || pending !== 2'd2) begin
            tests_failed++;
            $display("FAIL mid_blink_setup: led=%b pending=%0d, want led=1 pending=2", led, pending);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (led !== 1'b0 || pending !== 2'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_blink_reset: led=%b pending=%0d busy=%b, want 0 0 0", led, pending, busy);
        end
        tick();
        rst = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            tick();
            tests_run++;
            if (led !== 1'b0 || busy !== 1'b0 || pending !== 2'd0) begin
                tests_failed++;
                $display("FAIL after_reset cyc %0d: led=%b busy=%b pending=%0d, want 0 0 0", cyc, led, busy, pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue3();
        test_overflow();
        test_back_to_back();
        test_reset_mid_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
